// File: rtl/uart_baud_ctrl.sv
// UART baud controller: divisor register, 8x oversampling tick generator and
// optional 0x55 autobaud calibration (compiled in when BAUD_AUTOCAL_EN is defined).
module uart_baud_ctrl #(
    parameter int unsigned CLK_RATE  = 100_000_000,
    parameter int unsigned BAUD_RATE = 3_000_000,
    parameter int unsigned OVSAMP    = 8,
    parameter int unsigned DIV_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rx_i,
    input  logic             div_we_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             cal_req_i,
    output logic             cal_busy_o,
    output logic             cal_done_o,
    output logic             cal_err_o,
    output logic [DIV_W-1:0] div_o,
    output logic             ovsamp_tick_o
);

    localparam int unsigned DIV_RAW   = CLK_RATE / (OVSAMP * BAUD_RATE);
    localparam int unsigned DIV_RST_I = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_RST_I);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    generate
        if (OVSAMP != 8) begin : g_ovsamp_check
            $error("uart_baud_ctrl: OVSAMP must be 8");
        end
    endgenerate

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] tcnt_q, tcnt_d;
    logic             tick;
    logic             cal_load;
    logic [DIV_W-1:0] cal_div;

    assign tick          = (tcnt_q == (div_q - DIV_ONE));
    assign ovsamp_tick_o = tick;
    assign div_o         = div_q;

    // A manual write always wins over a calibration result landing in the same cycle.
    always_comb begin
        div_d  = div_q;
        tcnt_d = tick ? '0 : tcnt_q + DIV_ONE;
        if (div_we_i) begin
            div_d  = (div_i == '0) ? DIV_ONE : div_i;
            tcnt_d = '0;
        end else if (cal_load) begin
            div_d  = cal_div;
            tcnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= DIV_RST;
            tcnt_q <= '0;
        end else begin
            div_q  <= div_d;
            tcnt_q <= tcnt_d;
        end
    end

`ifdef BAUD_AUTOCAL_EN
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_EDGE = 2'd1;
    localparam logic [1:0] ST_MEASURE   = 2'd2;
    localparam logic [1:0] ST_FINISH    = 2'd3;
    localparam int MCNT_W = DIV_W + 6;
    localparam int RES_W  = DIV_W + 7;
    localparam logic [MCNT_W-1:0] MCNT_LAST = {{(MCNT_W-1){1'b1}}, 1'b0};

    logic [1:0]        state_q, state_d;
    logic              rx_q;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic [1:0]        ecnt_q, ecnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              fall;
    logic [RES_W-1:0]  res;
    logic              res_bad;

    assign fall = rx_q & ~rx_i;
    // Evaluated on the 5th edge, where the final count is mcnt_q+1; hence +1 on top of the +32 rounding.
    assign res     = (RES_W'(mcnt_q) + RES_W'(33)) >> 6;
    assign res_bad = (res == '0) || (res[RES_W-1:DIV_W] != '0);
    assign cal_div = res[DIV_W-1:0];

    assign cal_busy_o = (state_q != ST_IDLE);
    assign cal_done_o = done_q;
    assign cal_err_o  = err_q;

    always_comb begin
        state_d  = state_q;
        mcnt_d   = mcnt_q;
        ecnt_d   = ecnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cal_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cal_req_i) begin
                    state_d = ST_WAIT_EDGE;
                end
            end
            ST_WAIT_EDGE: begin
                if (fall) begin
                    mcnt_d  = '0;
                    ecnt_d  = '0;
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                mcnt_d = mcnt_q + 1'b1;
                if (mcnt_q == MCNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (fall) begin
                    ecnt_d = ecnt_q + 2'd1;
                    if (ecnt_q == 2'd3) begin
                        state_d = ST_FINISH;
                        if (res_bad) begin
                            err_d = 1'b1;
                        end else begin
                            done_d   = 1'b1;
                            cal_load = 1'b1;
                        end
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Software aborts a calibration by writing the divisor directly.
        if (div_we_i) begin
            state_d  = ST_IDLE;
            done_d   = 1'b0;
            err_d    = 1'b0;
            cal_load = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            rx_q    <= 1'b1;
            mcnt_q  <= '0;
            ecnt_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_q    <= rx_i;
            mcnt_q  <= mcnt_d;
            ecnt_q  <= ecnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
`else
    logic unused_cal_inputs;

    assign unused_cal_inputs = ^{rx_i, cal_req_i};
    assign cal_load   = 1'b0;
    assign cal_div    = '0;
    assign cal_busy_o = 1'b0;
    assign cal_done_o = 1'b0;
    assign cal_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed self-checking bench for uart_baud_ctrl; a second DIV_W=4 instance
// makes the measurement-overflow path reachable in a short run.
module tb_uart_baud_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        rx_i = 1'b1;
    logic        div_we_i = 1'b0;
    logic [15:0] div_i = '0;
    logic        cal_req_i = 1'b0;
    logic        cal_busy_o, cal_done_o, cal_err_o, ovsamp_tick_o;
    logic [15:0] div_o;

    logic        s_rx = 1'b1;
    logic        s_div_we = 1'b0;
    logic [3:0]  s_div_i = '0;
    logic        s_cal_req = 1'b0;
    logic        s_busy, s_done, s_err, s_tick;
    logic [3:0]  s_div_o;

    int n_checks = 0;
    int n_fail   = 0;

    int n_done, n_err, n_busy, div_at_done, busy_at_done, gap, gap_k;
    bit armed;

    always #5 clk_i = ~clk_i;

    uart_baud_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rx_i         (rx_i),
        .div_we_i     (div_we_i),
        .div_i        (div_i),
        .cal_req_i    (cal_req_i),
        .cal_busy_o   (cal_busy_o),
        .cal_done_o   (cal_done_o),
        .cal_err_o    (cal_err_o),
        .div_o        (div_o),
        .ovsamp_tick_o(ovsamp_tick_o)
    );

    uart_baud_ctrl #(.DIV_W(4)) small_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rx_i         (s_rx),
        .div_we_i     (s_div_we),
        .div_i        (s_div_i),
        .cal_req_i    (s_cal_req),
        .cal_busy_o   (s_busy),
        .cal_done_o   (s_done),
        .cal_err_o    (s_err),
        .div_o        (s_div_o),
        .ovsamp_tick_o(s_tick)
    );

    task automatic do_reset();
        rst_ni    = 1'b0;
        rx_i      = 1'b1;
        div_we_i  = 1'b0;
        div_i     = '0;
        cal_req_i = 1'b0;
        s_rx      = 1'b1;
        s_div_we  = 1'b0;
        s_cal_req = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic write_div(input logic [15:0] v);
        div_we_i = 1'b1;
        div_i    = v;
        @(negedge clk_i);
        div_we_i = 1'b0;
    endtask

    task automatic start_cal();
        cal_req_i = 1'b1;
        @(negedge clk_i);
        cal_req_i = 1'b0;
    endtask

    task automatic sample();
        if (cal_busy_o) n_busy++;
        if (cal_err_o) n_err++;
        if (cal_done_o) begin
            n_done++;
            div_at_done  = div_o;
            busy_at_done = cal_busy_o;
            armed        = 1'b1;
            gap_k        = 0;
        end else if (armed) begin
            gap_k++;
            if (ovsamp_tick_o && gap < 0) gap = gap_k;
        end
    endtask

    // 0x55 frame, LSB first: start(0), 1,0,1,0,1,0,1,0, stop(1)
    task automatic send_sync(input int bit_cycles, input int tail);
        logic [9:0] frame;
        frame = 10'b1010101010;
        n_done = 0; n_err = 0; n_busy = 0;
        div_at_done = -1; busy_at_done = -1; gap = -1; gap_k = 0; armed = 1'b0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < bit_cycles; c++) begin
                rx_i = frame[b];
                @(negedge clk_i);
                sample();
            end
        end
        rx_i = 1'b1;
        repeat (tail) begin
            @(negedge clk_i);
            sample();
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (div_o !== 16'd4) begin n_fail++; $display("[TB] FAIL reset_div: got %0d expected 4", div_o); end
        n_checks++;
        if ({cal_busy_o, cal_done_o, cal_err_o} !== 3'b000) begin
            n_fail++; $display("[TB] FAIL reset_cal: got %b expected 000", {cal_busy_o, cal_done_o, cal_err_o});
        end
        n_checks++;
        if (ovsamp_tick_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tick: got %b expected 0", ovsamp_tick_o); end
        rst_ni = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_i);
            n_checks++;
            if (ovsamp_tick_o !== ((c % 4) == 3)) begin
                n_fail++; $display("[TB] FAIL reset_tick_c%0d: got %b expected %b", c, ovsamp_tick_o, (c % 4) == 3);
            end
        end
        n_checks++;
        if (s_div_o !== 4'd4) begin n_fail++; $display("[TB] FAIL small_reset_div: got %0d expected 4", s_div_o); end
    endtask

    task automatic test_manual_write();
        do_reset();
        write_div(16'd10);
        n_checks++;
        if (div_o !== 16'd10) begin n_fail++; $display("[TB] FAIL wr10_div: got %0d expected 10", div_o); end
        n_checks++;
        if (ovsamp_tick_o !== 1'b0) begin n_fail++; $display("[TB] FAIL wr10_tick0: got %b expected 0", ovsamp_tick_o); end
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk_i);
            n_checks++;
            if (ovsamp_tick_o !== ((c % 10) == 9)) begin
                n_fail++; $display("[TB] FAIL wr10_tick_c%0d: got %b expected %b", c, ovsamp_tick_o, (c % 10) == 9);
            end
        end
        write_div(16'd0);
        n_checks++;
        if (div_o !== 16'd1) begin n_fail++; $display("[TB] FAIL wr0_clamp: got %0d expected 1", div_o); end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (ovsamp_tick_o !== 1'b1) begin n_fail++; $display("[TB] FAIL div1_tick_c%0d: got %b expected 1", c, ovsamp_tick_o); end
            @(negedge clk_i);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        div_we_i = 1'b1;
        div_i    = 16'd6;
        @(negedge clk_i);
        n_checks++;
        if (div_o !== 16'd6) begin n_fail++; $display("[TB] FAIL b2b_first: got %0d expected 6", div_o); end
        div_i = 16'd9;
        @(negedge clk_i);
        div_we_i = 1'b0;
        n_checks++;
        if (div_o !== 16'd9) begin n_fail++; $display("[TB] FAIL b2b_second: got %0d expected 9", div_o); end
    endtask

`ifdef BAUD_AUTOCAL_EN
    task automatic test_cal_160();
        do_reset();
        start_cal();
        n_checks++;
        if (cal_busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL cal160_busy: got %b expected 1", cal_busy_o); end
        send_sync(160, 20);
        n_checks++;
        if (n_done !== 1) begin n_fail++; $display("[TB] FAIL cal160_done_cnt: got %0d expected 1", n_done); end
        n_checks++;
        if (n_err !== 0) begin n_fail++; $display("[TB] FAIL cal160_err_cnt: got %0d expected 0", n_err); end
        n_checks++;
        if (div_at_done !== 20) begin n_fail++; $display("[TB] FAIL cal160_div_at_done: got %0d expected 20", div_at_done); end
        n_checks++;
        if (busy_at_done !== 1) begin n_fail++; $display("[TB] FAIL cal160_busy_in_finish: got %0d expected 1", busy_at_done); end
        n_checks++;
        if (gap !== 19) begin n_fail++; $display("[TB] FAIL cal160_first_tick: got %0d expected 19", gap); end
        n_checks++;
        if (div_o !== 16'd20 || cal_busy_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL cal160_final: got div %0d busy %b expected div 20 busy 0", div_o, cal_busy_o);
        end
    endtask

    task automatic test_cal_too_fast();
        do_reset();
        start_cal();
        send_sync(2, 10);
        n_checks++;
        if (n_err !== 1 || n_done !== 0) begin
            n_fail++; $display("[TB] FAIL fast_pulses: got err %0d done %0d expected err 1 done 0", n_err, n_done);
        end
        n_checks++;
        if (div_o !== 16'd4 || cal_busy_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL fast_final: got div %0d busy %b expected div 4 busy 0", div_o, cal_busy_o);
        end
    endtask

    task automatic test_abort();
        do_reset();
        start_cal();
        rx_i = 1'b0; repeat (3) @(negedge clk_i);
        rx_i = 1'b1; repeat (3) @(negedge clk_i);
        rx_i = 1'b0; repeat (3) @(negedge clk_i);
        n_checks++;
        if (cal_busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_pre_busy: got %b expected 1", cal_busy_o); end
        write_div(16'd7);
        n_checks++;
        if (div_o !== 16'd7 || cal_busy_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL abort_write: got div %0d busy %b expected div 7 busy 0", div_o, cal_busy_o);
        end
        n_done = 0; n_err = 0; n_busy = 0; armed = 1'b0; gap = -1;
        for (int c = 0; c < 40; c++) begin
            rx_i = ((c / 3) % 2) == 0;
            @(negedge clk_i);
            sample();
        end
        rx_i = 1'b1;
        n_checks++;
        if (n_done !== 0 || n_err !== 0 || n_busy !== 0) begin
            n_fail++; $display("[TB] FAIL abort_after: got done %0d err %0d busy %0d expected 0 0 0", n_done, n_err, n_busy);
        end
    endtask

    task automatic test_overflow();
        int err_at;
        do_reset();
        s_cal_req = 1'b1;
        @(negedge clk_i);
        s_cal_req = 1'b0;
        s_rx = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (s_busy !== 1'b1 || s_err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL ovf_start: got busy %b err %b expected busy 1 err 0", s_busy, s_err);
        end
        err_at = -1;
        for (int s = 1; s <= 1500; s++) begin
            @(negedge clk_i);
            if (s_err) begin
                err_at = s;
                break;
            end
        end
        n_checks++;
        if (err_at !== 1023) begin n_fail++; $display("[TB] FAIL ovf_err_cycle: got %0d expected 1023", err_at); end
        @(negedge clk_i);
        n_checks++;
        if (s_busy !== 1'b0 || s_div_o !== 4'd4) begin
            n_fail++; $display("[TB] FAIL ovf_after: got busy %b div %0d expected busy 0 div 4", s_busy, s_div_o);
        end
        s_rx = 1'b1;
    endtask

    task automatic test_reset_mid_cal();
        do_reset();
        write_div(16'd9);
        start_cal();
        rx_i = 1'b0;
        repeat (5) @(negedge clk_i);
        rst_ni = 1'b0;
        rx_i   = 1'b1;
        #1;
        n_checks++;
        if (div_o !== 16'd4 || {cal_busy_o, cal_done_o, cal_err_o} !== 3'b000) begin
            n_fail++; $display("[TB] FAIL midrst: got div %0d cal %b expected div 4 cal 000", div_o, {cal_busy_o, cal_done_o, cal_err_o});
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        start_cal();
        send_sync(160, 20);
        n_checks++;
        if (n_done !== 1 || div_o !== 16'd20) begin
            n_fail++; $display("[TB] FAIL midrst_recal: got done %0d div %0d expected done 1 div 20", n_done, div_o);
        end
    endtask
`else
    task automatic test_no_autocal();
        do_reset();
        start_cal();
        n_checks++;
        if (cal_busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL noacal_busy: got %b expected 0", cal_busy_o); end
        send_sync(160, 20);
        n_checks++;
        if (n_done !== 0 || n_err !== 0 || n_busy !== 0) begin
            n_fail++; $display("[TB] FAIL noacal_cal: got done %0d err %0d busy %0d expected 0 0 0", n_done, n_err, n_busy);
        end
        n_checks++;
        if (div_o !== 16'd4) begin n_fail++; $display("[TB] FAIL noacal_div: got %0d expected 4", div_o); end
    endtask
`endif

    initial begin
        $display("[TB] start");
        test_reset();
        test_manual_write();
        test_back_to_back();
`ifdef BAUD_AUTOCAL_EN
        test_cal_160();
        test_cal_too_fast();
        test_abort();
        test_overflow();
        test_reset_mid_cal();
`else
        test_no_autocal();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_baud_ctrl.md
# uart_baud_ctrl

- Owns the UART oversampling clock enable.
- Holds the active baud divisor.
- Emits one `ovsamp_tick_o` pulse every `div_o` clock cycles. The UART RX/TX paths use this pulse as their 8× oversampling strobe.
- Sets the divisor from three sources: a compile-time default, a runtime write from the debug-module side, or an autobaud calibration that times a 0x55 sync character on the RX line.

## Interface
Parameters:
- `CLK_RATE`, default 100_000_000: system clock in Hz.
- `BAUD_RATE`, default 3_000_000: reset baud rate.
- `OVSAMP`, default 8: oversampling factor. Fixed at 8; any other value is a parameter error.
- `DIV_W`, default 16: divisor width.

Ports:
- `clk_i`, in, 1: system clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `rx_i`, in, 1: serial RX line, already synchronised to `clk_i`, idle high.
- `div_we_i`, in, 1: manual divisor write strobe.
- `div_i`, in, DIV_W: divisor value for a manual write.
- `cal_req_i`, in, 1: single-cycle request to start autobaud calibration.
- `cal_busy_o`, out, 1: calibration in progress.
- `cal_done_o`, out, 1: one-cycle pulse on successful calibration.
- `cal_err_o`, out, 1: one-cycle pulse on failed calibration.
- `div_o`, out, DIV_W: active divisor.
- `ovsamp_tick_o`, out, 1: oversampling strobe.

## Operation
Reset values:
- `DIV_RST` = max(1, CLK_RATE/(OVSAMP*BAUD_RATE)). With default parameters this is 4.
- `div_o` = `DIV_RST`; tick counter = 0; state = IDLE.
- All `cal_*` outputs = 0.

Tick generator:
- Counter `tcnt` (DIV_W bits) counts 0..`div_o`−1, then wraps.
- `ovsamp_tick_o` = (`tcnt` == `div_o`−1). It is decoded from registers only, with no input path.
- Any divisor change (manual or calibrated) resets `tcnt` to 0 in the same cycle `div_o` updates.

Manual write:
- `div_we_i`=1 loads `div_i` into `div_o` on the next edge. A value of 0 is clamped to 1.
- If the write arrives while calibration is busy, the calibration aborts to IDLE with no done or err pulse.

Calibration FSM:
- States: IDLE, WAIT_EDGE, MEASURE, FINISH.
- IDLE → WAIT_EDGE on `cal_req_i`. `cal_req_i` is ignored in any other state.
- WAIT_EDGE waits for a falling edge (`rx_q`=1, `rx_i`=0). On the edge it clears `mcnt` and `ecnt` and enters MEASURE. There is no timeout; software aborts by writing the divisor.
- MEASURE increments `mcnt` each cycle and counts falling edges in `ecnt`. On the 4th further falling edge (5th overall, i.e. 8 bit periods of 0x55) it enters FINISH.
- If `mcnt` reaches 2^(DIV_W+6)−1 first, the FSM saturates, pulses `cal_err_o` and returns to IDLE.
- FINISH computes `res` = (`mcnt`+32)>>6 in DIV_W+7 bits, which is rounded `mcnt`/(8·OVSAMP).
  - `res`==0 or `res`≥2^DIV_W: pulse `cal_err_o`, `div_o` unchanged.
  - Otherwise: load `div_o`=`res`, pulse `cal_done_o`, reset `tcnt`.
  - Return to IDLE in all cases.
- `cal_busy_o`=1 in WAIT_EDGE, MEASURE and FINISH.
- `mcnt` width is DIV_W+6.

## Timing
- `cal_req_i` at edge k gives `cal_busy_o`=1 from k+1.
- Falling-edge detection uses the registered `rx_q`, so an edge is seen in the cycle `rx_i` first reads 0.
- Measured N is the number of cycles from the detection cycle of the 1st falling edge to the detection cycle of the 5th.
- FINISH lasts one cycle. In it, `cal_done_o`/`cal_err_o` pulse, `div_o` is updated and `tcnt`=0, and `cal_busy_o` is still 1.
- After any divisor load, the first tick comes `div_o` cycles later.
- With `div_o`=1, `ovsamp_tick_o` is high every cycle.
- Reset asserted mid-calibration returns everything to reset values immediately; no pulse is produced.

## Configuration
- `BAUD_AUTOCAL_EN` defined: calibration FSM and counters are compiled in, as described above.
- Not defined: the FSM is removed, `cal_req_i` and `rx_i` are ignored, and `cal_busy_o`, `cal_done_o` and `cal_err_o` are tied to 0. Manual write and the tick generator are unchanged.

## Test plan
- **Reset defaults:** release reset with default parameters → `div_o`=4, `ovsamp_tick_o` high at cycles 3, 7, 11 after release; `cal_*`=0.
- **Manual write:** `div_we_i` with `div_i`=10 → `div_o`=10 next cycle, ticks every 10 cycles starting 10 cycles after the load. `div_i`=0 → `div_o`=1 and a tick every cycle.
- **Calibration, 160-cycle bit:** `cal_req_i`, then drive 0x55 (LSB-first, start/stop) at 160 cycles per bit → N=1280, `div_o`=20, one `cal_done_o` pulse, `cal_busy_o` back to 0.
- **Calibration, too fast:** 0x55 at 2 cycles per bit → N=16, `res`=0 → `cal_err_o` pulse, `div_o` unchanged at 4.
- **Overflow and abort:**
  - Single falling edge, then `rx_i` held low → `cal_err_o` after 2^22−1 cycles.
  - Separate run: `div_we_i` during MEASURE → `div_o` takes the written value, FSM returns to IDLE, no done or err pulse.
- **Reset mid-calibration:** assert `rst_ni` during MEASURE → `div_o`=4, `cal_busy_o`=0, and a new calibration succeeds afterwards. Build with `BAUD_AUTOCAL_EN` undefined → `cal_req_i` has no effect and all `cal_*` outputs stay 0.
